qam16_demodulator: RTL and testbench
====================================

# qam16_demodulator

Coherent 16-QAM symbol demodulator: the receive-side counterpart of the transmitter's modulator. It mixes the incoming passband sample stream with the `sin`/`cos` outputs of `local_oscillator`, integrates each product over one symbol period, and slices the two sums into a Gray-coded 4-bit symbol. It sits between the sample source and the receiver's bit deserializer. It shares the transmitter's LO and its symbol-per-period convention.

## Interface
Parameters:
- `SAMPLES_PER_SYM`, 16: samples (clocks) per symbol; one LO period. Power of two, 2 to 256.
- `THRESH`, 2**30: outer decision boundary magnitude, applied to the integrated value.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: level enable. While high, one sample is consumed per clock.
- `rx_sample`  in  16: signed received passband sample.
- `sin`  in  16: signed LO quadrature reference, sample-aligned with `rx_sample`.
- `cos`  in  16: signed LO in-phase reference, sample-aligned with `rx_sample`.
- `symbol`  out  4: decided symbol. `[3:2]` is the I level and `[1:0]` is the Q level, both Gray coded.
- `sym_valid`  out  1: one-cycle pulse marking `symbol` as new.
- `busy`  out  1: high while not IDLE.

## Operation
- Accumulator width is `ACC_W = 32 + $clog2(SAMPLES_PER_SYM)`. All arithmetic is signed. Products are full 32-bit and sign-extended into the accumulators, so no saturation is needed.
- States:
  - IDLE: accumulators held at 0, counter held at 0. If `start`=1, go to INTEG. The sample present in that same cycle is the first sample of the symbol.
  - INTEG: each cycle, `acc_i += rx_sample*cos` and `acc_q += rx_sample*sin`, and `cnt` increments.
    - When `cnt == SAMPLES_PER_SYM-1`, the final sums (acc plus the current product) load into the dump registers. At the same time the accumulators clear, `cnt` wraps to 0, and the `dump_pend` flag is set.
    - The state stays INTEG, so the next symbol begins on the very next sample with no gap.
  - Dropping `start` to 0 in INTEG: go to IDLE and clear the accumulators and `cnt`. The partial symbol is discarded and produces no `sym_valid`. A dump that is already pending still completes.
- Slicer: per axis, on the dump value `v`:
  - `v > THRESH` gives +3, code `10`.
  - `0 <= v <= THRESH` gives +1, code `11`.
  - `-THRESH <= v < 0` gives -1, code `01`.
  - `v < -THRESH` gives -3, code `00`.
  - At exact equality, `v == 0` and `v == THRESH` both give +1; `v == -THRESH` gives -1.
- `symbol` is registered. It holds its last value until the next `sym_valid`.
- `rst` overrides everything: state IDLE, accumulators and dump registers 0, `cnt`=0, `dump_pend`=0, `symbol`=0, `sym_valid`=0, `busy`=0. Reset applied mid-symbol or mid-dump loses the symbol silently.

## Timing
- The last sample of a symbol is captured at edge E. The dump registers load at E. `symbol` and `sym_valid` register at E+1, so `sym_valid` is high for exactly the one cycle after edge E+1. Fixed latency is 2 edges from the last sample.
- Steady state gives one `sym_valid` every `SAMPLES_PER_SYM` clocks with no bubbles.
- `busy` rises at the edge where IDLE sees `start`=1 and falls at the edge where INTEG sees `start`=0.
- `start` and `rst` both high: reset wins.

## Structure
- Package `qam16_pkg` holds:
  - the state enum (IDLE, INTEG);
  - the Gray level codes `LVL_P3=2'b10`, `LVL_P1=2'b11`, `LVL_M1=2'b01`, `LVL_M3=2'b00`. The modulator's mapper must use the same constants.
- Sub-module `qam16_integrator`: one multiply-accumulate-and-dump channel (product, accumulator, dump register, clear). It is instantiated twice, once for I and once for Q. The FSM, counter and slicer live in the top level.

## Test plan
All scenarios use `SAMPLES_PER_SYM`=16 and `THRESH`=2**30.
- Reset: hold `rst`=1 for 3 clocks with `start`=1 and random inputs. Required: `symbol`=0, `sym_valid`=0, `busy`=0 throughout.
- Constant I drive: `cos`=16384, `sin`=0, `rx_sample`=8192 for 16 samples (I sum 2^31, Q sum 0). Required: `symbol`=4'b1011 and a single `sym_valid`, 2 edges after the 16th sample.
- Boundaries, `sin`=0:
  - `cos`=16384, `rx_sample`=4096 (I sum exactly 2^30) gives I=`11`.
  - `rx_sample`=-4096 gives I=`01`.
  - `rx_sample`=-8192 gives I=`00`.
- Back-to-back: 4 consecutive symbols with no gap, using `rx_sample`=±8192 against `sin`=16384, `cos`=0. Required: 4 `sym_valid` pulses 16 clocks apart, with Q codes matching the sign pattern.
- Abort: drop `start` after 7 samples, then restart. Required: no `sym_valid` for the aborted symbol. The next full symbol decodes correctly with no residue from the partial sums.
- LO loopback: drive the real `local_oscillator` with a known modulated stream for all 16 symbols. Required: every 4-bit symbol is recovered in order.

Source files
------------

// File: rtl/qam16_pkg.sv
// Shared definitions for the 16-QAM modem: FSM states, Gray level codes and
// the per-axis decision slicer.
package qam16_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      INTEG = 1'b1
   } state_e;

   localparam logic [1:0] LVL_P3 = 2'b10;
   localparam logic [1:0] LVL_P1 = 2'b11;
   localparam logic [1:0] LVL_M1 = 2'b01;
   localparam logic [1:0] LVL_M3 = 2'b00;

   // Zero and +thresh fall in the +1 region; -thresh falls in the -1 region.
   function automatic logic [1:0] slice_level(input logic signed [63:0] v,
                                              input logic signed [63:0] thresh);
      logic [1:0] lvl;
      if (v > thresh) begin
         lvl = LVL_P3;
      end else if (v >= 64'sd0) begin
         lvl = LVL_P1;
      end else if (v >= -thresh) begin
         lvl = LVL_M1;
      end else begin
         lvl = LVL_M3;
      end
      return lvl;
   endfunction

endpackage

// File: rtl/qam16_demodulator_integrator.sv
// One multiply-accumulate-and-dump channel. The dump register keeps its
// value across a clear so a symbol already completed survives an abort.
module qam16_integrator
   import qam16_pkg::*;
#(
   parameter int ACC_W = 36
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    last,
   input  logic                    clear,
   input  logic signed [15:0]      sample,
   input  logic signed [15:0]      lo_ref,
   output logic signed [ACC_W-1:0] dump
);

   logic signed [31:0]      prod_s;
   logic signed [ACC_W-1:0] sum_s;
   logic signed [ACC_W-1:0] acc_r;

   assign prod_s = sample * lo_ref;
   assign sum_s  = acc_r + $signed({{(ACC_W-32){prod_s[31]}}, prod_s});

   // Accumulate one product per sample; on the last sample hand the sum to dump.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r <= '0;
         dump  <= '0;
      end else if (clear) begin
         acc_r <= '0;
      end else if (en) begin
         if (last) begin
            dump  <= sum_s;
            acc_r <= '0;
         end else begin
            acc_r <= sum_s;
         end
      end else begin
         acc_r <= acc_r;
      end
   end

endmodule

// File: rtl/qam16_demodulator.sv
// Coherent 16-QAM demodulator: I/Q integrate-and-dump over one LO period,
// then a Gray-coded four-level slicer per axis.
module qam16_demodulator
   import qam16_pkg::*;
#(
   parameter int                 SAMPLES_PER_SYM = 16,
   parameter logic signed [63:0] THRESH          = 64'sd1073741824
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic signed [15:0] rx_sample,
   input  logic signed [15:0] sin,
   input  logic signed [15:0] cos,
   output logic [3:0]         symbol,
   output logic               sym_valid,
   output logic               busy
);

   localparam int ACC_W = 32 + $clog2(SAMPLES_PER_SYM);
   localparam int CNT_W = $clog2(SAMPLES_PER_SYM);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_SYM - 1);
   localparam logic [0:0] ST_IDLE  = IDLE;
   localparam logic [0:0] ST_INTEG = INTEG;

   logic [0:0]              state_r;
   logic [CNT_W-1:0]        cnt_r;
   logic                    dump_pend_r;
   logic                    last_s;
   logic signed [ACC_W-1:0] dump_i_s;
   logic signed [ACC_W-1:0] dump_q_s;

   // The sample seen while IDLE with start high is already the first of a symbol.
   assign last_s = start && (cnt_r == CNT_LAST);
   assign busy   = (state_r == ST_INTEG);

   qam16_integrator #(.ACC_W(ACC_W)) u_int_i (
      .clk    (clk),
      .rst    (rst),
      .en     (start),
      .last   (last_s),
      .clear  (!start),
      .sample (rx_sample),
      .lo_ref (cos),
      .dump   (dump_i_s)
   );

   qam16_integrator #(.ACC_W(ACC_W)) u_int_q (
      .clk    (clk),
      .rst    (rst),
      .en     (start),
      .last   (last_s),
      .clear  (!start),
      .sample (rx_sample),
      .lo_ref (sin),
      .dump   (dump_q_s)
   );

   // State register: INTEG while start stays high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE:  state_r <= start ? ST_INTEG : ST_IDLE;
            ST_INTEG: state_r <= start ? ST_INTEG : ST_IDLE;
            default:  state_r <= ST_IDLE;
         endcase
      end
   end

   // Sample counter within the current symbol.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (!start || last_s) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   // Slice the dumped sums one edge after they load.
   always_ff @(posedge clk) begin
      if (rst) begin
         dump_pend_r <= 1'b0;
         sym_valid   <= 1'b0;
         symbol      <= 4'b0000;
      end else begin
         dump_pend_r <= last_s;
         sym_valid   <= dump_pend_r;
         if (dump_pend_r) begin
            symbol <= {slice_level(64'(dump_i_s), THRESH),
                       slice_level(64'(dump_q_s), THRESH)};
         end else begin
            symbol <= symbol;
         end
      end
   end

endmodule

// File: tb/tb_qam16_demodulator.sv
// Randomized bench for qam16_demodulator with an arithmetic reference model
// and a queue of expected symbols tagged with their due clock edge.
module tb_qam16_demodulator;

   localparam int                 N = 16;
   localparam logic signed [63:0] T = 64'sd1073741824;
   localparam real                PI = 3.14159265358979;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic signed [15:0] rx_sample;
   logic signed [15:0] sin;
   logic signed [15:0] cos;
   logic [3:0]         symbol;
   logic               sym_valid;
   logic               busy;

   always #5 clk = ~clk;

   qam16_demodulator #(.SAMPLES_PER_SYM(N), .THRESH(T)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rx_sample (rx_sample),
      .sin       (sin),
      .cos       (cos),
      .symbol    (symbol),
      .sym_valid (sym_valid),
      .busy      (busy)
   );

   typedef struct {
      logic [3:0]  sym;
      logic [63:0] due;
   } exp_t;

   exp_t               exp_q[$];
   int                 n_checks = 0;
   int                 n_fail   = 0;
   logic [63:0]        edge_cnt = 64'd0;
   bit                 mon_en   = 1'b0;
   logic signed [15:0] rx_a[N];
   logic signed [15:0] c_a[N];
   logic signed [15:0] s_a[N];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int level_of(input longint v);
      if (v > T)        return 3;
      else if (v >= 0)  return 1;
      else if (v >= -T) return -1;
      else              return -3;
   endfunction

   function automatic logic [1:0] gray_of(input int lvl);
      case (lvl)
         3:       return 2'b10;
         1:       return 2'b11;
         -1:      return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   function automatic real amp_of(input logic [1:0] code);
      case (code)
         2'b10:   return 3.0;
         2'b11:   return 1.0;
         2'b01:   return -1.0;
         default: return -3.0;
      endcase
   endfunction

   always @(posedge clk) edge_cnt <= edge_cnt + 64'd1;

   // Every pulse must match the head of the expected queue, on its due edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (sym_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", {63'd0, sym_valid}, 64'd0);
            end else begin
               check("valid_time", edge_cnt, exp_q[0].due);
               check("symbol", {60'd0, symbol}, {60'd0, exp_q[0].sym});
               void'(exp_q.pop_front());
            end
         end else if (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
            check("valid_missing", {63'd0, sym_valid}, 64'd1);
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic drive(input logic st, input logic signed [15:0] r,
                        input logic signed [15:0] c, input logic signed [15:0] s);
      @(negedge clk);
      start     = st;
      rx_sample = r;
      cos       = c;
      sin       = s;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
   endtask

   task automatic fill_const(input int r, input int c, input int s);
      for (int i = 0; i < N; i++) begin
         rx_a[i] = 16'(r);
         c_a[i]  = 16'(c);
         s_a[i]  = 16'(s);
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < N; i++) begin
         rx_a[i] = 16'(int'($urandom_range(0, 32767)) - 16384);
         c_a[i]  = 16'(int'($urandom_range(0, 8191)) - 4096);
         s_a[i]  = 16'(int'($urandom_range(0, 8191)) - 4096);
      end
   endtask

   // Ideal transmitter: levels on cos/sin carriers, one LO period per symbol.
   task automatic fill_lo(input logic [3:0] code);
      real ph;
      for (int i = 0; i < N; i++) begin
         ph      = 2.0 * PI * real'(i) / real'(N);
         c_a[i]  = 16'(int'(16384.0 * $cos(ph)));
         s_a[i]  = 16'(int'(16384.0 * $sin(ph)));
         rx_a[i] = 16'(int'(4096.0 * (amp_of(code[3:2]) * $cos(ph) + amp_of(code[1:0]) * $sin(ph))));
      end
   endtask

   // Drive one full symbol; expectation is the model's decision or a given code.
   task automatic send_symbol(input logic [3:0] want, input bit use_want);
      longint si = 0;
      longint sq = 0;
      exp_t   e;
      for (int i = 0; i < N; i++) begin
         drive(1'b1, rx_a[i], c_a[i], s_a[i]);
         si += longint'(rx_a[i]) * longint'(c_a[i]);
         sq += longint'(rx_a[i]) * longint'(s_a[i]);
      end
      e.due = edge_cnt + 64'd2;
      e.sym = use_want ? want : {gray_of(level_of(si)), gray_of(level_of(sq))};
      exp_q.push_back(e);
   endtask

   initial begin
      logic [3:0] bb;
      rst = 1'b1;
      start = 1'b1;
      rx_sample = 16'sd0;
      cos = 16'sd0;
      sin = 16'sd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rx_sample = 16'($urandom);
         cos = 16'($urandom);
         sin = 16'($urandom);
         check("rst_symbol", {60'd0, symbol}, 64'd0);
         check("rst_valid", {63'd0, sym_valid}, 64'd0);
         check("rst_busy", {63'd0, busy}, 64'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      mon_en = 1'b1;
      idle(2);

      fill_const(8192, 16384, 0);
      send_symbol(4'b1011, 1'b1);
      check("busy_high", {63'd0, busy}, 64'd1);
      idle(2);
      check("busy_low", {63'd0, busy}, 64'd0);
      idle(3);
      check("symbol_hold", {60'd0, symbol}, 64'd11);

      fill_const(4096, 16384, 0);
      send_symbol(4'b1111, 1'b1);
      idle(3);
      fill_const(-4096, 16384, 0);
      send_symbol(4'b0111, 1'b1);
      idle(3);
      fill_const(-8192, 16384, 0);
      send_symbol(4'b0011, 1'b1);
      idle(3);

      bb = 4'($urandom);
      for (int k = 0; k < 4; k++) begin
         fill_const(bb[k] ? 8192 : -8192, 0, 16384);
         send_symbol({2'b11, bb[k] ? 2'b10 : 2'b00}, 1'b1);
      end
      idle(3);

      fill_const(8192, 16384, 16384);
      for (int i = 0; i < 7; i++) drive(1'b1, rx_a[i], c_a[i], s_a[i]);
      idle(2);
      fill_const(-8192, 16384, 0);
      send_symbol(4'b0011, 1'b1);
      idle(2);

      for (int k = 0; k < 12; k++) begin
         fill_random();
         if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < int'($urandom_range(1, N - 1)); i++) drive(1'b1, rx_a[i], c_a[i], s_a[i]);
            idle(1);
            fill_random();
         end
         send_symbol(4'b0000, 1'b0);
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
      end
      idle(3);

      for (int k = 0; k < 16; k++) begin
         fill_lo(4'(k));
         send_symbol(4'(k), 1'b1);
      end
      idle(6);
      check("queue_drain", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
